// File: rtl/aes_pkg.sv
// Shared AES definitions: block geometry, engine FSM states and GF(2^8) helpers
// used by the forward and inverse S-box lanes.
package aes_pkg;

  localparam int AES_BLOCK_W = 128;
  localparam int AES_BYTES   = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic bit lane_count_legal(input int lanes);
    return lanes inside {1, 2, 4, 8, 16};
  endfunction

  // Multiply modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] aa;
    acc = '0;
    aa  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  // Multiplicative inverse as a^254; zero maps to zero as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

endpackage

// File: rtl/inv_sbox.sv
// Inverse AES S-box: inverse affine map (constant 0x05) followed by the field inverse.
module inv_sbox
  import aes_pkg::*;
(
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  localparam logic [7:0] INV_AFF_C = 8'h05;

  logic [7:0] pre_b;

  for (genvar gi = 0; gi < 8; gi++) begin : g_iaff
    assign pre_b[gi] = in_byte[(gi + 2) % 8] ^ in_byte[(gi + 5) % 8]
                     ^ in_byte[(gi + 7) % 8] ^ INV_AFF_C[gi];
  end

  assign out_byte = gf_inv(pre_b);

endmodule

// File: rtl/sbox.sv
// Forward AES S-box: field inverse followed by the affine map with constant 0x63.
module sbox
  import aes_pkg::*;
(
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  localparam logic [7:0] AFF_C = 8'h63;

  logic [7:0] inv_b;
  assign inv_b = gf_inv(in_byte);

  for (genvar gi = 0; gi < 8; gi++) begin : g_aff
    assign out_byte[gi] = inv_b[gi] ^ inv_b[(gi + 4) % 8] ^ inv_b[(gi + 5) % 8]
                        ^ inv_b[(gi + 6) % 8] ^ inv_b[(gi + 7) % 8] ^ AFF_C[gi];
  end

endmodule

// File: rtl/sub_byte_seq.sv
// Sequential SubBytes: LANES S-box lanes walk the 16-byte state one group per cycle,
// MSB group first, with valid/ready on both sides and per-block forward/inverse mode.
module sub_byte_seq
  import aes_pkg::*;
#(
  parameter int LANES  = 4,
  parameter bit INV_EN = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_BLOCK_W-1:0] in_data,
  input  logic                   in_inv,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_BLOCK_W-1:0] out_data,
  output logic                   busy
);

  localparam int N  = AES_BYTES / LANES;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int GW = LANES * 8;

  if (!lane_count_legal(LANES)) begin : g_bad_lanes
    $error("sub_byte_seq: LANES must be 1, 2, 4, 8 or 16");
  end

  state_t                 state_q, state_d;
  logic [AES_BLOCK_W-1:0] work_q, work_d;
  logic [AES_BLOCK_W-1:0] out_q, out_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   mode_q, mode_d;

  logic [GW-1:0]          grp_tab [2**CW];
  logic [GW-1:0]          grp_in;
  logic [GW-1:0]          grp_out;
  logic [AES_BLOCK_W-1:0] work_sub;
  logic                   accept;

  // Table padded to a power of two so the counter never indexes out of range.
  for (genvar gi = 0; gi < 2**CW; gi++) begin : g_grp
    if (gi < N) begin : g_real
      assign grp_tab[gi] = work_q[AES_BLOCK_W-1-gi*GW -: GW];
    end else begin : g_pad
      assign grp_tab[gi] = '0;
    end
  end
  assign grp_in = grp_tab[cnt_q];

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [7:0] fwd_b;
    logic [7:0] lane_b;
    sbox u_sbox (.in_byte(grp_in[GW-1-gi*8 -: 8]), .out_byte(fwd_b));
    if (INV_EN) begin : g_inv
      logic [7:0] inv_b;
      inv_sbox u_inv_sbox (.in_byte(grp_in[GW-1-gi*8 -: 8]), .out_byte(inv_b));
      assign lane_b = mode_q ? inv_b : fwd_b;
    end else begin : g_fwd_only
      assign lane_b = fwd_b;
    end
    assign grp_out[GW-1-gi*8 -: 8] = lane_b;
  end

  always_comb begin
    work_sub = work_q;
    for (int g = 0; g < N; g++) begin
      if (cnt_q == CW'(g)) work_sub[AES_BLOCK_W-1-g*GW -: GW] = grp_out;
    end
  end

  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_data  = out_q;

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    out_d   = out_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          work_d  = in_data;
          mode_d  = in_inv & INV_EN;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        work_d = work_sub;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          out_d   = work_sub;
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          // Same-edge hand-off: the result leaves as the next block enters.
          if (in_valid) begin
            work_d  = in_data;
            mode_d  = in_inv & INV_EN;
            cnt_d   = '0;
            state_d = RUN;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      work_q  <= '0;
      out_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

endmodule

// File: tb/tb_sub_byte_seq.sv
// Bench for sub_byte_seq: directed vectors, a lane sweep on four extra instances,
// backpressure, mid-run reset and a randomized scoreboard against a table model.
module tb_sub_byte_seq;

  logic         clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Main instance: LANES=4, INV_EN=1.
  logic         rst, in_valid, in_ready, in_inv, out_valid, out_ready, busy;
  logic [127:0] in_data, out_data;

  sub_byte_seq #(.LANES(4), .INV_EN(1'b1)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_inv(in_inv), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy)
  );

  // Sweep instances: LANES=1,2,8,16, forward only, sharing one input side.
  function automatic int sw_lanes(input int i);
    case (i)
      0:       return 1;
      1:       return 2;
      2:       return 8;
      default: return 16;
    endcase
  endfunction

  logic         s_rst, s_in_valid, s_in_inv, s_out_ready;
  logic [127:0] s_in_data;
  logic         s_in_ready  [4];
  logic         s_out_valid [4];
  logic         s_busy      [4];
  logic [127:0] s_out_data  [4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_sw
    sub_byte_seq #(.LANES(sw_lanes(gi)), .INV_EN(1'b0)) u_sw (
      .clk(clk), .rst(s_rst), .in_valid(s_in_valid), .in_ready(s_in_ready[gi]),
      .in_data(s_in_data), .in_inv(s_in_inv), .out_valid(s_out_valid[gi]),
      .out_ready(s_out_ready), .out_data(s_out_data[gi]), .busy(s_busy[gi])
    );
  end

  // Reference model: S-box built from the definition (brute-force inverse + rotations).
  logic [7:0] fwd_tab [256];
  logic [7:0] inv_tab [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    while (y != 0) begin
      if (y[0]) r = r ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox_model(input logic [7:0] x);
    logic [7:0] inv = 8'h00;
    for (int y = 1; y < 256; y++) if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
    return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] ref_sub(input logic [127:0] blk, input logic inv);
    logic [127:0] r;
    for (int b = 0; b < 16; b++) begin
      r[127-8*b -: 8] = inv ? inv_tab[blk[127-8*b -: 8]] : fwd_tab[blk[127-8*b -: 8]];
    end
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One block through the main instance with out_ready held high.
  task automatic xfer(input logic [127:0] d, input logic inv, output int lat,
                      output int bcnt, output logic [127:0] res);
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_inv = inv; out_ready = 1'b1;
    #1 check("xfer_in_ready", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0; in_data = rand128(); in_inv = ~inv;
    lat = -1; bcnt = 0; res = '0;
    for (int j = 0; j < 40; j++) begin
      if (busy) bcnt++;
      if (out_valid && lat < 0) begin lat = j; res = out_data; end
      @(negedge clk);
    end
    $display("txn main in=%h inv=%0d out=%h lat=%0d busy=%0d", d, inv, res, lat, bcnt);
  endtask

  int           sw_lat  [4];
  int           sw_bcnt [4];
  logic [127:0] sw_res  [4];

  task automatic sw_xfer(input logic [127:0] d);
    @(negedge clk);
    s_in_valid = 1'b1; s_in_data = d; s_in_inv = 1'b1; s_out_ready = 1'b1;
    #1 for (int i = 0; i < 4; i++) check("sw_in_ready", s_in_ready[i], 1'b1);
    @(negedge clk);
    s_in_valid = 1'b0; s_in_data = rand128();
    for (int i = 0; i < 4; i++) begin sw_lat[i] = -1; sw_bcnt[i] = 0; sw_res[i] = '0; end
    for (int j = 0; j < 24; j++) begin
      for (int i = 0; i < 4; i++) begin
        if (s_busy[i]) sw_bcnt[i]++;
        if (s_out_valid[i] && sw_lat[i] < 0) begin sw_lat[i] = j; sw_res[i] = s_out_data[i]; end
      end
      @(negedge clk);
    end
    for (int i = 0; i < 4; i++)
      $display("txn sweep lanes=%0d in=%h out=%h lat=%0d busy=%0d",
               sw_lanes(i), d, sw_res[i], sw_lat[i], sw_bcnt[i]);
  endtask

  initial begin
    int           lat, bcnt, w, got, sent, cyc;
    logic [127:0] res, blk_a, blk_b, exp_a, exp_b, blk;
    logic         inv_a, inv_b, pending;
    logic [127:0] q[$];

    for (int x = 0; x < 256; x++) fwd_tab[x] = sbox_model(8'(x));
    for (int x = 0; x < 256; x++) inv_tab[fwd_tab[x]] = 8'(x);

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_inv = 1'b0; out_ready = 1'b0;
    s_rst = 1'b1; s_in_valid = 1'b0; s_in_data = '0; s_in_inv = 1'b0; s_out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_sw_in_ready", s_in_ready[0], 1'b1);
    rst = 1'b0; s_rst = 1'b0;

    xfer(128'h00112233445566778899aabbccddeeff, 1'b0, lat, bcnt, res);
    check("fwd_data", res, 128'h638293c31bfc33f5c4eeacea4bc12816);
    check("fwd_latency", lat, 4);
    check("fwd_busy_cycles", bcnt, 5);
    xfer(128'h638293c31bfc33f5c4eeacea4bc12816, 1'b1, lat, bcnt, res);
    check("inv_data", res, 128'h00112233445566778899aabbccddeeff);
    check("inv_latency", lat, 4);

    // Sweep with zero state; in_inv=1 must be ignored by forward-only instances.
    sw_xfer('0);
    for (int i = 0; i < 4; i++) begin
      check("sweep_data", sw_res[i], {16{8'h63}});
      check("sweep_latency", sw_lat[i], 16 / sw_lanes(i));
      check("sweep_busy_cycles", sw_bcnt[i], 16 / sw_lanes(i) + 1);
    end

    // Backpressure, then simultaneous output and input transfers.
    blk_a = rand128(); inv_a = 1'(($urandom));
    blk_b = rand128(); inv_b = 1'(($urandom));
    exp_a = ref_sub(blk_a, inv_a); exp_b = ref_sub(blk_b, inv_b);
    @(negedge clk);
    in_valid = 1'b1; in_data = blk_a; in_inv = inv_a; out_ready = 1'b0;
    @(negedge clk);
    in_data = blk_b; in_inv = inv_b;
    w = 0;
    while (!out_valid && w < 20) begin @(negedge clk); w++; end
    check("bp_reached_done", out_valid, 1'b1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
      check("bp_out_valid", out_valid, 1'b1);
      check("bp_out_data", out_data, exp_a);
      check("bp_in_ready", in_ready, 1'b0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    check("bp_handoff_in_ready", in_ready, 1'b1);
    check("bp_handoff_out_valid", out_valid, 1'b1);
    check("bp_handoff_data", out_data, exp_a);
    @(negedge clk);
    in_valid = 1'b0; in_data = rand128(); in_inv = ~inv_b;
    #1;
    check("bp_after_out_valid", out_valid, 1'b0);
    check("bp_after_busy", busy, 1'b1);
    lat = 0;
    while (!out_valid && lat < 20) begin @(negedge clk); lat++; end
    check("bp_second_latency", lat, 4);
    check("bp_second_data", out_data, exp_b);
    $display("txn bp first=%h second=%h", exp_a, out_data);
    repeat (2) @(negedge clk);

    // Reset on the second RUN edge of the LANES=1 instance.
    @(negedge clk);
    s_in_valid = 1'b1; s_in_data = rand128(); s_out_ready = 1'b1;
    @(negedge clk);
    s_in_valid = 1'b0;
    @(negedge clk);
    s_rst = 1'b1;
    @(negedge clk);
    #1;
    check("mid_rst_out_valid", s_out_valid[0], 1'b0);
    check("mid_rst_out_data", s_out_data[0], '0);
    check("mid_rst_in_ready", s_in_ready[0], 1'b1);
    check("mid_rst_busy", s_busy[0], 1'b0);
    s_rst = 1'b0;
    blk = rand128();
    sw_xfer(blk);
    for (int i = 0; i < 4; i++) begin
      check("post_rst_data", sw_res[i], ref_sub(blk, 1'b0));
      check("post_rst_latency", sw_lat[i], 16 / sw_lanes(i));
    end

    // Random traffic with stalls on both sides.
    got = 0; sent = 0; cyc = 0; pending = 1'b0;
    while (got < 1000 && cyc < 60000) begin
      @(negedge clk);
      cyc++;
      if (!pending) begin
        in_valid = 1'b0;
        in_inv   = 1'(($urandom));
        if (sent < 1000 && $urandom_range(0, 9) < 7) begin
          in_valid = 1'b1; in_data = rand128(); pending = 1'b1;
        end
      end
      out_ready = ($urandom_range(0, 9) < 6);
      #1;
      if (out_valid && out_ready) begin
        check("rand_q_nonempty", 32'(q.size() != 0), 1);
        if (q.size() != 0) begin
          check("rand_data", out_data, q.pop_front());
          $display("txn rand %0d out=%h", got, out_data);
        end
        got++;
      end
      if (in_valid && in_ready) begin
        q.push_back(ref_sub(in_data, in_inv));
        sent++;
        pending = 1'b0;
      end
    end
    check("rand_out_count", got, 1000);
    check("rand_in_count", sent, 1000);
    check("rand_drained", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sub_byte_seq.md
Name:
sub_byte_seq

Overview:
Sequential, lane-parametrised AES SubBytes engine that generalises the fixed 16-S-box combinational substitution layer. It substitutes a 128-bit state using LANES S-box lanes over 16/LANES cycles, trading area for latency. It optionally supports inverse SubBytes for the decryption datapath. It sits between AddRoundKey and ShiftRows in iterative AES-128 cores, with valid/ready handshakes on both sides.

Parameters:
LANES, 4, number of parallel S-box lanes; legal values 1, 2, 4, 8, 16; any other value is an elaboration error.
INV_EN, 1, 1 instantiates inverse S-box lanes and honours in_inv; 0 means forward only, and in_inv is ignored.

Ports:
clk  input  1  single clock; all logic rising-edge.
rst  input  1  synchronous reset, active-high.
in_valid  input  1  input state is valid.
in_ready  output  1  engine can accept; transfer occurs when in_valid && in_ready at a rising edge.
in_data  input  128  state; byte 0 = [127:120] … byte 15 = [7:0].
in_inv  input  1  1 = inverse S-box; sampled with in_data.
out_valid  output  1  result is valid.
out_ready  input  1  downstream accepts; transfer occurs when out_valid && out_ready.
out_data  output  128  substituted state, same byte order as in_data.
busy  output  1  high in RUN and DONE.

Behaviour:
- N = 16/LANES. FSM states: IDLE, RUN, DONE. Beat counter: $clog2(N) bits, min 1 bit.
- Reset (rst=1 at an edge): state=IDLE, out_valid=0, out_data=0, busy=0, counter=0, mode=0.
  - Overrides everything, including mid-RUN or mid-DONE; any in-flight block is discarded and no partial result is ever presented.
- in_ready = (state==IDLE) || (state==DONE && out_ready). Combinational from state and out_ready only; never from in_valid.
- IDLE, on accept: latch in_data into the working register, latch mode = in_inv & INV_EN, counter=0, go to RUN.
- RUN, each edge: substitute byte group g = counter, i.e. bytes g*LANES … g*LANES+LANES-1 (MSB group first), in place, then increment the counter.
  - Untouched bytes hold their values.
  - On the edge processing group N-1: go to DONE and copy the full result to out_data.
- Latency: out_valid is high starting in the cycle after the Nth edge following the accept edge. Examples: LANES=16 gives 1 cycle; LANES=1 gives 16 cycles.
- DONE: out_valid=1; out_data is held stable while out_ready=0 (arbitrary backpressure length).
  - out_ready=1 and no new accept: go to IDLE and clear out_valid.
  - out_ready=1 and in_valid=1 on the same edge: the output is consumed and the new block is accepted. Go directly to RUN, clear out_valid, counter=0.
  - Throughput in this case is one block per N+1 cycles.
- in_valid while busy (not DONE+out_ready): ignored; upstream must hold data per valid/ready rules.
- Mode is per block. in_inv changing during RUN has no effect.
- Result is bytewise identical to 16 parallel forward (or inverse) S-boxes, for every LANES value.
- out_data changes only on the RUN→DONE edge or on reset.

Decomposition:
- Shared package aes_pkg:
  - AES_BLOCK_W=128 and AES_BYTES=16.
  - FSM state enum: IDLE, RUN, DONE.
  - Function lane_count_legal(LANES) used for the elaboration check.
- Reuse the existing sbox module for forward lanes, via a generate loop of LANES instances.
- New sub-module inv_sbox: 8-bit in, 8-bit out, combinational inverse S-box. Generated only when INV_EN=1.
- Per lane, a 2:1 mux selects the sbox or inv_sbox output by mode.
- Byte-group selection is a mux indexed by the counter.

Test Plan:
- Forward, LANES=4: in_data=00112233445566778899aabbccddeeff, in_inv=0, out_ready=1. Required: out_data=638293c31bfc33f5c4eeacea4bc12816, out_valid rises 4 edges after the accept.
- Inverse, INV_EN=1: in_data=638293c31bfc33f5c4eeacea4bc12816, in_inv=1. Required: out_data=00112233445566778899aabbccddeeff.
- Sweep LANES=1,2,8,16 with in_data=all zeros. Required: out_data=63 repeated 16 times, with latency 16, 8, 2, 1 respectively; busy high for exactly latency+1 cycles when out_ready=1.
- Backpressure: hold out_ready=0 for 10 cycles in DONE. Required: out_data and out_valid stable, in_ready=0. Then out_ready=1 with in_valid=1 and a second block: both transfers occur on the same edge, and the second result is correct.
- Reset mid-operation: assert rst at the 2nd RUN edge (LANES=1). Required: next cycle out_valid=0, out_data=0, in_ready=1, busy=0, and a fresh block then completes correctly.
- Random: 1000 random blocks, random in_inv, random out_ready stalls. Required: match a reference model in order, with no dropped or duplicated blocks.
